// File: rtl/progmem_port2_arbiter.sv
// Two-master round-robin arbiter for the s2 port of the dual-port program memory.
// Supports bounded grant locking and routes the 1-cycle read data back to its owner.
module progmem_port2_arbiter #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUMWORDS = 12288,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                freeze,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   address2,
    output logic [DATA_W/8-1:0] byteenable2,
    output logic                chipselect2,
    output logic                write2,
    output logic [DATA_W-1:0]   writedata2,
    output logic                clken2,
    input  logic [DATA_W-1:0]   readdata2
);

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    logic              last_grant_q, last_grant_d;
    logic [3:0]        lock_cnt_q, lock_cnt_d;
    logic              rd_pend_q, rd_owner_q, rd_oor_q;
    logic [DATA_W-1:0] rd_hold0_q, rd_hold1_q;

    logic              req0, req1, lock_hold;
    logic              grant0, grant1, any_grant;
    logic              gnt_read, gnt_write, in_range, rd_accept;
    logic [DATA_W-1:0] rd_word;

    assign req0      = m0_read | m0_write;
    assign req1      = m1_read | m1_write;
    assign lock_hold = (last_grant_q ? m1_lock : m0_lock) && (lock_cnt_q < LOCK_LIM);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !freeze) begin
            if (req0 && req1) begin
                // Lock keeps the previous owner; otherwise alternate.
                if (lock_hold) begin
                    grant1 = last_grant_q;
                    grant0 = ~last_grant_q;
                end else begin
                    grant1 = ~last_grant_q;
                    grant0 = last_grant_q;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign any_grant = grant0 | grant1;

    assign address2    = grant1 ? m1_address    : m0_address;
    assign byteenable2 = grant1 ? m1_byteenable : m0_byteenable;
    assign writedata2  = grant1 ? m1_writedata  : m0_writedata;
    assign gnt_write   = grant1 ? m1_write      : m0_write;
    assign gnt_read    = grant1 ? m1_read       : m0_read;

    assign in_range    = 32'(address2) < NUMWORDS;
    assign chipselect2 = any_grant & in_range;
    assign write2      = chipselect2 & gnt_write;
    assign clken2      = ~freeze;
    assign rd_accept   = any_grant & gnt_read & ~gnt_write;

    assign m0_waitrequest = reset | (req0 & ~grant0);
    assign m1_waitrequest = reset | (req1 & ~grant1);

    always_comb begin
        last_grant_d = any_grant ? grant1 : last_grant_q;
        lock_cnt_d   = lock_cnt_q;
        if (!(req0 && req1)) begin
            lock_cnt_d = 4'd0;
        end else if (any_grant) begin
            if (grant1 == last_grant_q) begin
                lock_cnt_d = (lock_cnt_q == LOCK_LIM) ? lock_cnt_q : lock_cnt_q + 4'd1;
            end else begin
                lock_cnt_d = 4'd0;
            end
        end
    end

    assign rd_word          = rd_oor_q ? '0 : readdata2;
    assign m0_readdatavalid = rd_pend_q & ~rd_owner_q & ~reset;
    assign m1_readdatavalid = rd_pend_q &  rd_owner_q & ~reset;
    assign m0_readdata      = reset ? '0 : (m0_readdatavalid ? rd_word : rd_hold0_q);
    assign m1_readdata      = reset ? '0 : (m1_readdatavalid ? rd_word : rd_hold1_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            lock_cnt_q   <= 4'd0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_oor_q     <= 1'b0;
            rd_hold0_q   <= '0;
            rd_hold1_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_accept;
            if (rd_accept) begin
                rd_owner_q <= grant1;
                rd_oor_q   <= ~in_range;
            end
            if (m0_readdatavalid) rd_hold0_q <= rd_word;
            if (m1_readdatavalid) rd_hold1_q <= rd_word;
        end
    end

endmodule

// File: tb/tb_progmem_port2_arbiter.sv
// Bench for progmem_port2_arbiter: directed vector table, hand-written corner
// sequences, and random traffic checked against a rule-level reference model.
module tb_progmem_port2_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int NUMWORDS = 12288;
    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, freeze, preload;
    logic [13:0] m0_address, m1_address, address2;
    logic [3:0]  m0_byteenable, m1_byteenable, byteenable2;
    logic        m0_read, m0_write, m0_lock, m0_waitrequest, m0_readdatavalid;
    logic        m1_read, m1_write, m1_lock, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic [31:0] writedata2, readdata2;
    logic        chipselect2, write2, clken2;

    progmem_port2_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUMWORDS(NUMWORDS), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .write2(write2), .writedata2(writedata2), .clken2(clken2), .readdata2(readdata2)
    );

    function automatic logic [31:0] word_init(int i);
        return (i == 256) ? 32'h1122_3344 : (32'h5A5A_0000 ^ 32'(i));
    endfunction

    // Memory port s2: registered address, one-cycle read latency, stalled by clken2.
    logic [31:0] mem [NUMWORDS];
    logic [31:0] mem_q;
    assign readdata2 = mem_q;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NUMWORDS; i++) mem[i] <= word_init(i);
            mem_q <= 32'h0;
        end else if (clken2 && chipselect2 && int'(address2) < NUMWORDS) begin
            if (write2) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable2[b]) mem[address2][8*b +: 8] <= writedata2[8*b +: 8];
            end else begin
                mem_q <= mem[address2];
            end
        end
    end

    typedef struct {
        bit          rst, frz;
        bit          rd0, wr0, lk0;
        logic [13:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        bit          rd1, wr1, lk1;
        logic [13:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        bit          ew0, ew1, ecs, erv0, erv1;
    } vec_t;

    function automatic vec_t mk(bit rst, bit frz, bit rd0, bit lk0, logic [13:0] a0,
                                bit rd1, logic [13:0] a1,
                                bit ew0, bit ew1, bit ecs, bit erv0, bit erv1);
        vec_t v;
        v.rst = rst; v.frz = frz;
        v.rd0 = rd0; v.wr0 = 1'b0; v.lk0 = lk0; v.a0 = a0; v.be0 = 4'hF; v.wd0 = 32'h0;
        v.rd1 = rd1; v.wr1 = 1'b0; v.lk1 = 1'b0; v.a1 = a1; v.be1 = 4'hF; v.wd1 = 32'h0;
        v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.erv0 = erv0; v.erv1 = erv1;
        return v;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    int          m_last, m_cnt, m_owner;
    bit          m_pend;
    logic [31:0] m_pdata, m_hold0, m_hold1;
    logic [31:0] shadow [NUMWORDS];

    // Samples of the last evaluated cycle, for hand-written checks
    logic        s_w0, s_w1, s_cs, s_we, s_rv0, s_rv1;
    logic [31:0] s_rd0, s_rd1;

    task automatic step(input vec_t v, input bit use_exp);
        bit          r0, r1, hold, inr, grd, gwr, ecs, ewe, ev0, ev1;
        int          g;
        logic [13:0] ga;
        logic [3:0]  gbe;
        logic [31:0] gwd, erd0, erd1;
        reset = v.rst; freeze = v.frz;
        m0_read = v.rd0; m0_write = v.wr0; m0_lock = v.lk0; m0_address = v.a0;
        m0_byteenable = v.be0; m0_writedata = v.wd0;
        m1_read = v.rd1; m1_write = v.wr1; m1_lock = v.lk1; m1_address = v.a1;
        m1_byteenable = v.be1; m1_writedata = v.wd1;
        @(negedge clk);
        r0 = v.rd0 | v.wr0;
        r1 = v.rd1 | v.wr1;
        g  = -1;
        if (!v.rst && !v.frz) begin
            if (r0 && r1) begin
                hold = ((m_last == 1) ? v.lk1 : v.lk0) && (m_cnt < LOCK_MAX);
                g = hold ? m_last : 1 - m_last;
            end else if (r0) g = 0;
            else if (r1) g = 1;
        end
        ga  = (g == 1) ? v.a1  : v.a0;
        gbe = (g == 1) ? v.be1 : v.be0;
        gwd = (g == 1) ? v.wd1 : v.wd0;
        gwr = (g == 1) ? v.wr1 : ((g == 0) ? v.wr0 : 1'b0);
        grd = (g == 1) ? v.rd1 : ((g == 0) ? v.rd0 : 1'b0);
        inr = int'(ga) < NUMWORDS;
        ecs = (g >= 0) && inr;
        ewe = ecs && gwr;
        ev0 = !v.rst && m_pend && m_owner == 0;
        ev1 = !v.rst && m_pend && m_owner == 1;
        erd0 = v.rst ? 32'h0 : (ev0 ? m_pdata : m_hold0);
        erd1 = v.rst ? 32'h0 : (ev1 ? m_pdata : m_hold1);

        chk("waitrequest0", m0_waitrequest, v.rst || (r0 && g != 0));
        chk("waitrequest1", m1_waitrequest, v.rst || (r1 && g != 1));
        chk("chipselect2", chipselect2, ecs);
        chk("write2", write2, ewe);
        chk("address2", address2, ga);
        chk("byteenable2", byteenable2, gbe);
        chk("writedata2", writedata2, gwd);
        chk("clken2", clken2, !v.frz);
        chk("readdatavalid0", m0_readdatavalid, ev0);
        chk("readdatavalid1", m1_readdatavalid, ev1);
        chk("readdata0", m0_readdata, erd0);
        chk("readdata1", m1_readdata, erd1);
        if (use_exp) begin
            chk("tbl_waitrequest0", m0_waitrequest, v.ew0);
            chk("tbl_waitrequest1", m1_waitrequest, v.ew1);
            chk("tbl_chipselect2", chipselect2, v.ecs);
            chk("tbl_readdatavalid0", m0_readdatavalid, v.erv0);
            chk("tbl_readdatavalid1", m1_readdatavalid, v.erv1);
        end
        s_w0 = m0_waitrequest; s_w1 = m1_waitrequest; s_cs = chipselect2; s_we = write2;
        s_rv0 = m0_readdatavalid; s_rv1 = m1_readdatavalid;
        s_rd0 = m0_readdata; s_rd1 = m1_readdata;

        @(posedge clk);
        #1;
        cyc++;
        if (v.rst) begin
            m_last = 1; m_cnt = 0; m_pend = 1'b0; m_owner = 0;
            m_hold0 = 32'h0; m_hold1 = 32'h0;
        end else begin
            if (ev0) m_hold0 = m_pdata;
            if (ev1) m_hold1 = m_pdata;
            if (!(r0 && r1)) m_cnt = 0;
            else if (g >= 0) m_cnt = (g == m_last) ? ((m_cnt < LOCK_MAX) ? m_cnt + 1 : m_cnt) : 0;
            if (g >= 0) m_last = g;
            m_pend  = (g >= 0) && grd && !gwr;
            m_owner = g;
            m_pdata = inr ? shadow[ga] : 32'h0;
            if (ewe)
                for (int b = 0; b < 4; b++)
                    if (gbe[b]) shadow[ga][8*b +: 8] = gwd[8*b +: 8];
        end
    endtask

    function automatic logic [13:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 14'(NUMWORDS + $urandom_range(0, 4095));
        return 14'($urandom_range(0, 15));
    endfunction

    vec_t tbl [$];
    vec_t v;

    initial begin
        for (int i = 0; i < NUMWORDS; i++) shadow[i] = word_init(i);
        m_last = 1; m_cnt = 0; m_pend = 1'b0; m_owner = 0; m_pdata = 32'h0;
        m_hold0 = 32'h0; m_hold1 = 32'h0;
        preload = 1'b1;
        v = mk(1, 0, 0, 0, 14'h0, 0, 14'h0, 1, 1, 0, 0, 0);
        reset = 1'b1; freeze = 1'b0;
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = 0; m0_byteenable = 0;
        m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = 0; m1_byteenable = 0;
        m1_writedata = 0;
        @(posedge clk);
        #1;
        preload = 1'b0;

        //            rst frz rd0 lk0 a0     rd1 a1     ew0 ew1 cs rv0 rv1
        tbl.push_back(mk(1, 0, 1, 0, 14'h10, 1, 14'h20, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h10, 1, 14'h20, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h10, 1, 14'h20, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h10, 1, 14'h20, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 14'h10, 1, 14'h20, 1, 0, 1, 1, 0));
        // m0 locks: one round-robin grant, four locked grants, then m1 once
        tbl.push_back(mk(0, 0, 1, 1, 14'h10, 1, 14'h20, 0, 1, 1, 0, 1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 1, 1, 14'h10, 1, 14'h20, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 14'h10, 1, 14'h20, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 14'h10, 1, 14'h20, 0, 1, 1, 0, 1));
        // read on m1, then freeze for three cycles
        tbl.push_back(mk(0, 0, 0, 0, 14'h10, 1, 14'h20, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 14'h10, 1, 14'h20, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 14'h10, 1, 14'h20, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 14'h10, 1, 14'h20, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h10, 1, 14'h20, 0, 1, 1, 0, 0));
        // m0 read, then reset discards the pending read
        tbl.push_back(mk(0, 0, 1, 0, 14'h11, 0, 14'h20, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h12, 0, 14'h20, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 14'h13, 1, 14'h21, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 14'h13, 1, 14'h21, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 14'h13, 0, 14'h21, 0, 0, 0, 1, 0));
        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Partial-byte write followed by read-back
        v = mk(0, 0, 0, 0, 14'h100, 0, 14'h0, 0, 0, 0, 0, 0);
        v.wr0 = 1; v.wd0 = 32'hDEAD_BEEF; v.be0 = 4'b0011;
        step(v, 1'b0);
        chk("rmw_write_accept", s_w0, 1'b0);
        chk("rmw_write2", s_we, 1'b1);
        v = mk(0, 0, 1, 0, 14'h100, 0, 14'h0, 0, 0, 0, 0, 0);
        step(v, 1'b0);
        v = mk(0, 0, 0, 0, 14'h0, 0, 14'h0, 0, 0, 0, 0, 0);
        step(v, 1'b0);
        chk("rmw_readdata", s_rd0, 32'h1122_BEEF);
        chk("rmw_valid0", s_rv0, 1'b1);
        chk("rmw_valid1", s_rv1, 1'b0);

        // Out-of-range read and write on m1
        v = mk(0, 0, 0, 0, 14'h0, 1, 14'h3000, 0, 0, 0, 0, 0);
        step(v, 1'b0);
        chk("oor_read_accept", s_w1, 1'b0);
        chk("oor_read_cs", s_cs, 1'b0);
        v = mk(0, 0, 0, 0, 14'h0, 0, 14'(12300), 0, 0, 0, 0, 0);
        v.wr1 = 1; v.wd1 = 32'hFFFF_FFFF;
        step(v, 1'b0);
        chk("oor_read_valid", s_rv1, 1'b1);
        chk("oor_read_data", s_rd1, 32'h0);
        chk("oor_write_accept", s_w1, 1'b0);
        chk("oor_write_cs", s_cs, 1'b0);
        chk("oor_write2", s_we, 1'b0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int k0, k1;
            v = mk(0, 0, 0, 0, 14'h0, 0, 14'h0, 0, 0, 0, 0, 0);
            v.rst = ($urandom_range(0, 39) == 0);
            v.frz = ($urandom_range(0, 7) == 0);
            k0 = $urandom_range(0, 3);
            k1 = $urandom_range(0, 3);
            v.rd0 = (k0 == 1 || k0 == 2); v.wr0 = (k0 == 3);
            v.rd1 = (k1 == 1 || k1 == 2); v.wr1 = (k1 == 3);
            v.lk0 = $urandom_range(0, 1) == 1; v.lk1 = $urandom_range(0, 1) == 1;
            v.a0 = rand_addr(); v.a1 = rand_addr();
            v.be0 = 4'($urandom); v.be1 = 4'($urandom);
            v.wd0 = $urandom; v.wd1 = $urandom;
            step(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/progmem_port2_arbiter.md
Name: progmem_port2_arbiter

Overview:
Two-master arbiter that shares the second (s2) port of the dual-port on-chip program memory. Typical masters are a debug/boot loader and a DMA engine. Each master has its own Avalon-MM pipelined slave interface. The block grants at most one transfer per clock to the memory port, using round-robin order with an optional bounded lock for read-modify-write sequences. It routes the one-cycle-latency read data back to the owning master.

Parameters:
ADDR_W, 14, word address width of the memory port
DATA_W, 32, data width; byteenable width is DATA_W/8
NUMWORDS, 12288, implemented depth; word addresses >= NUMWORDS are out of range
LOCK_MAX, 4, maximum consecutive grants a locking master may hold while the other master is requesting (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
freeze  in  1  when high, no new grants are issued
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  DATA_W/8  master 0 byte lanes
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_lock  in  1  master 0 requests grant retention
m0_waitrequest  out  1  master 0 request not accepted this cycle
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  (same set of ports as m0_*)  master 1
address2  out  ADDR_W  to memory port s2
byteenable2  out  DATA_W/8  to memory
chipselect2  out  1  to memory
write2  out  1  to memory
writedata2  out  DATA_W  to memory
clken2  out  1  to memory; equals ~freeze
readdata2  in  DATA_W  from memory; unregistered output

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values (registered state): last_grant=1, so m0 wins the first contention; lock_cnt=0; rd_pend=0; rd_owner=0; rd_oor=0.
- Reset values (outputs): m0/m1_readdatavalid=0, m*_readdata=0, chipselect2=0, write2=0.
- While reset is high, both m*_waitrequest=1.
- Request: req_i = m_i_read | m_i_write. Read and write asserted together on one master is illegal; write takes precedence.
- Grant, combinational within the cycle:
  - No grant if freeze or reset is high.
  - If only one master requests, that master is granted.
  - If both request and lock_hold is active, last_grant is granted.
  - Otherwise, when both request, the master other than last_grant is granted.
- lock_hold = m_{last_grant}_lock & (lock_cnt < LOCK_MAX).
- lock_cnt counts consecutive grants to the same master while the other master is requesting. It increments on each such grant and clears when the grant changes or the other master stops requesting. It saturates at LOCK_MAX, so the locking master then loses the next contended cycle.
- waitrequest: m_i_waitrequest = req_i & ~grant_i. It is driven as 0 when there is no request. A request is accepted in the cycle where waitrequest is low.
- Memory drive: address2, byteenable2 and writedata2 are muxed from the granted master. With no grant, they hold the m0 values.
  - chipselect2 = grant & in_range, where in_range = address < NUMWORDS.
  - write2 = chipselect2 & granted write.
  - An out-of-range write is accepted and dropped.
- Read pipeline:
  - On an accepted read, set rd_pend=1, rd_owner=granted index and rd_oor=~in_range at the clock edge.
  - In the next cycle, m_{rd_owner}_readdatavalid=1 and readdata = rd_oor ? 0 : readdata2. Fixed read latency is 1.
  - Back-to-back reads from either master sustain one read per cycle.
  - The other master's readdatavalid stays 0 and its readdata holds its previous value.
- freeze:
  - Blocks new grants.
  - A read accepted in the cycle before freeze still completes its readdatavalid.
  - clken2 low stalls the memory address register; readdata2 still presents the previously registered word.
- Reset mid-operation: a pending read is discarded and no readdatavalid is issued for it. Arbitration restarts with m0 preferred.
- Throughput: one transfer per cycle total, with no idle cycles between grants.

Test Plan:
- Reset, then m0 and m1 both read (m0 addr 0x0010, m1 addr 0x0020) held continuously -> grants alternate m0,m1,m0,m1. Each readdatavalid arrives exactly 1 cycle after its acceptance with the word at the matching address. No cycle has both grants.
- m0 writes 0xDEADBEEF to 0x0100 with byteenable 0b0011, then reads 0x0100 (memory preloaded 0x11223344) -> readdata 0x1122BEEF one cycle after read acceptance; m1_readdatavalid stays 0.
- LOCK_MAX=4, m0_lock=1 and m0 reads continuously, m1 reads continuously -> m0 granted 1 cycle by round-robin, then 4 locked cycles, then m1 granted once; the pattern repeats. lock_cnt never exceeds 4.
- m1 reads address 12288 (0x3000) and writes 0xFFFFFFFF to 12300 -> read accepted, chipselect2=0, readdatavalid with readdata 0. The write is accepted with write2=0 and memory is unchanged.
- Read accepted on m1, then freeze=1 for 3 cycles with both masters requesting -> m1_readdatavalid fires the next cycle; both waitrequests stay 1 for 3 cycles; clken2=0; grants resume after freeze falls.
- m0 read accepted, then reset pulsed for 1 cycle in the following cycle -> no readdatavalid for that read. After reset, with both masters requesting, m0 is granted first.
